// File: rtl/mult_input_conditioner.sv
// Button/switch front end for the shift-add multiplier:
// synchronize, debounce, one-shot Run/ClearA_LoadB, freeze S while busy.
module mult_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_HOLD_CYCLES = 32,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run_btn,
    input  logic       ClearA_LoadB_btn,
    input  logic [7:0] SW,
    output logic       Run,
    output logic       ClearA_LoadB,
    output logic [7:0] S,
    output logic       Busy
);

    localparam int MAX_CNT = (DEBOUNCE_CYCLES > RUN_HOLD_CYCLES) ?
                             DEBOUNCE_CYCLES : RUN_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RUN_HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic REL_LVL = (BTN_ACTIVE_LOW != 0);
    localparam int RUN_I = 0;
    localparam int CLR_I = 1;

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    logic [1:0]    btn_s1;
    logic [1:0]    btn_s2;
    logic [1:0]    pressed;
    logic [1:0]    fire;
    logic [7:0]    sw_s1;
    logic [7:0]    sw_s2;
    state_t        state_q [2];
    state_t        state_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [CW-1:0] hold_cnt;
    logic          run_ok;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Sync FFs reset to the released raw level so reset never looks like a press.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            btn_s1 <= {2{REL_LVL}};
            btn_s2 <= {2{REL_LVL}};
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= {ClearA_LoadB_btn, Run_btn};
            btn_s2 <= btn_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    assign pressed = btn_s2 ^ {2{REL_LVL}};

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!Reset) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // The IDLE->ARM edge counts as the first stable cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = sat_inc(cnt_q[i]);
            fire[i]    = 1'b0;
            unique case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (pressed[i]) state_d[i] = ARM;
                end
                ARM: begin
                    if (!pressed[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_d[i] == DEB_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        fire[i]    = 1'b1;
                    end
                end
                HELD: begin
                    cnt_d[i] = '0;
                    if (!pressed[i]) state_d[i] = REL;
                end
                REL: begin
                    if (pressed[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_d[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign run_ok = fire[RUN_I] & ~fire[CLR_I] & ~Busy;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Run          <= 1'b0;
            ClearA_LoadB <= 1'b0;
            S            <= '0;
            Busy         <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            Run          <= run_ok;
            ClearA_LoadB <= fire[CLR_I];
            if (!Busy) S <= sw_s2;
            if (run_ok) begin
                Busy     <= 1'b1;
                hold_cnt <= '0;
            end else if (Busy) begin
                if (sat_inc(hold_cnt) == HOLD_LAST) begin
                    Busy     <= 1'b0;
                    hold_cnt <= '0;
                end else begin
                    hold_cnt <= sat_inc(hold_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_input_conditioner.sv
// Directed bench for mult_input_conditioner; pulses are
// checked against a queue of expected (kind, S, cycle) entries.
module tb_mult_input_conditioner;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run_btn;
    logic       ClearA_LoadB_btn;
    logic [7:0] SW;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic       Busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e;

    typedef struct {
        bit         clr;
        logic [7:0] s;
        int         at;
    } exp_t;

    exp_t q[$];

    mult_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .RUN_HOLD_CYCLES(8),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Run_btn         (Run_btn),
        .ClearA_LoadB_btn(ClearA_LoadB_btn),
        .SW              (SW),
        .Run             (Run),
        .ClearA_LoadB    (ClearA_LoadB),
        .S               (S),
        .Busy            (Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Pulse is expected high in the cycle after edge drive+6
    // (2 sync edges + 4 stable cycles, counted from the next edge).
    task automatic expect_pulse(input bit clr, input logic [7:0] s);
        exp_t x;
        x.clr = clr;
        x.s   = s;
        x.at  = cyc + 6;
        q.push_back(x);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge Clk);
            if (Run === 1'b1 || ClearA_LoadB === 1'b1) begin
                chk("pulse_exclusive", 32'(Run & ClearA_LoadB), 0);
                chk("pulse_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    x = q.pop_front();
                    chk("pulse_kind", 32'(ClearA_LoadB), 32'(x.clr));
                    chk("pulse_run", 32'(Run), 32'(!x.clr));
                    chk("pulse_s", 32'(S), 32'(x.s));
                    chk("pulse_cycle", 32'(cyc), 32'(x.at));
                end
            end
        end
    endtask

    initial begin
        Reset            = 1'b0;
        Run_btn          = 1'b1;
        ClearA_LoadB_btn = 1'b1;
        SW               = 8'hC5;
        fork
            monitor();
        join_none

        // 1: reset state, then S follows SW within 3 edges
        tick(3);
        chk("rst_run", 32'(Run), 0);
        chk("rst_clr", 32'(ClearA_LoadB), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_s", 32'(S), 0);
        Reset = 1'b1;
        tick(3);
        chk("s_track_c5", 32'(S), 32'h0C5);

        // 2: long ClearA_LoadB press gives one pulse
        ClearA_LoadB_btn = 1'b0;
        expect_pulse(1'b1, 8'hC5);
        tick(20);
        chk("clr_no_busy", 32'(Busy), 0);
        ClearA_LoadB_btn = 1'b1;
        SW = 8'h07;
        tick(10);
        chk("s_track_07", 32'(S), 32'h07);

        // 3: 3-cycle bounce is rejected, then a real press
        Run_btn = 1'b0;
        tick(3);
        Run_btn = 1'b1;
        tick(6);
        chk("bounce_no_busy", 32'(Busy), 0);
        Run_btn = 1'b0;
        expect_pulse(1'b0, 8'h07);
        e = cyc + 6;
        tick(6);
        chk("run_busy_set", 32'(Busy), 1);
        chk("run_s", 32'(S), 32'h07);

        // 4: S frozen during busy; re-press during busy gives no pulse
        tick(2);
        SW = 8'h03;
        tick(2);
        Run_btn = 1'b1;
        tick(2);
        Run_btn = 1'b0;
        chk("freeze_busy_e6", 32'(Busy), 1);
        chk("freeze_s_e6", 32'(S), 32'h07);
        tick(1);
        chk("freeze_busy_e7", 32'(Busy), 1);
        chk("freeze_s_e7", 32'(S), 32'h07);
        tick(1);
        chk("busy_fall_cycle", 32'(cyc), 32'(e + 8));
        chk("busy_fall", 32'(Busy), 0);
        chk("s_hold_at_fall", 32'(S), 32'h07);
        tick(1);
        chk("s_resume_03", 32'(S), 32'h03);
        tick(5);
        Run_btn = 1'b1;
        tick(12);

        // 5: simultaneous press -> only ClearA_LoadB
        Run_btn          = 1'b0;
        ClearA_LoadB_btn = 1'b0;
        expect_pulse(1'b1, 8'h03);
        tick(10);
        chk("both_no_busy", 32'(Busy), 0);
        Run_btn          = 1'b1;
        ClearA_LoadB_btn = 1'b1;
        tick(12);

        // 6: reset mid-busy and mid-ARM aborts, held button re-debounces
        Run_btn = 1'b0;
        expect_pulse(1'b0, 8'h03);
        tick(6);
        Run_btn = 1'b1;
        tick(1);
        ClearA_LoadB_btn = 1'b0;
        tick(2);
        chk("pre_rst_busy", 32'(Busy), 1);
        Reset = 1'b0;
        tick(1);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_s", 32'(S), 0);
        chk("mid_rst_clr", 32'(ClearA_LoadB), 0);
        Reset = 1'b1;
        expect_pulse(1'b1, 8'h03);
        tick(12);
        ClearA_LoadB_btn = 1'b1;
        tick(10);

        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
